stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32, stack capacity in entries.
REQ-002 SHALL have parameter DW, default 3, entry width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports req0/req1  in  1  single-cycle request pulse per requester.
REQ-006 SHALL have ports op0/op1  in  1  operation qualifier: 0=push, 1=pop; sampled with req.
REQ-007 SHALL have ports din0/din1  in  DW  push data; sampled with req.
REQ-008 SHALL have ports done0/done1  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports dout0/dout1  out  DW  pop data; valid while done is high.
REQ-010 SHALL have ports err0/err1  out  1  rejected operation; valid while done is high.
REQ-011 SHALL have port ready  out  1  high when the block is not draining.
REQ-012 SHALL have port count  out  6  current stack occupancy, 0..DEPTH.
REQ-013 SHALL have port stk_push  out  1  push strobe to the stack.
REQ-014 SHALL have port stk_pop  out  1  pop strobe to the stack.
REQ-015 SHALL have port stk_din  out  DW  data to the stack.
REQ-016 SHALL have port stk_dout  in  DW  stack output; updates on the edge after a pop strobe.
REQ-017 SHALL have port stk_empty  in  1  stack underflow flag; set on a pop issued at pointer 0.

Function
REQ-018 SHALL register each reqN pulse into pendN, with opN/dinN captured into per-requester holding registers.
REQ-019 SHALL ignore reqN while pendN=1: no overwrite of held op/data, no error.
REQ-020 SHALL use FSM states DRAIN, IDLE, ISSUE, SETTLE, RESP.
REQ-021 DRAIN: stk_pop=1 every cycle; on stk_empty==1 go to IDLE and drop stk_pop; X or 0 on stk_empty never exits.
REQ-022 IDLE: with any pend set, pick the winner round-robin (the requester not served last wins a tie; after reset requester 0 wins), then clear its pend.
REQ-023 IDLE: a push with count==DEPTH or a pop with count==0 goes straight to RESP with err=1 and issues no stack strobe.
REQ-024 IDLE: a legal operation goes to ISSUE.
REQ-025 ISSUE: exactly one cycle of stk_push (stk_din=held data) or stk_pop; count +1 or -1 at the end of the cycle.
REQ-026 SETTLE: no strobes; capture stk_dout at the end of the cycle for a pop.
REQ-027 RESP: doneN=1 for one cycle only for the winner; doutN=captured data (pop) or 0 (push/err); errN as decided; then go to IDLE.
REQ-028 Latency, legal op: done 4 cycles after the req edge (pend, ISSUE, SETTLE, RESP); error op: done 2 cycles after the req edge.
REQ-029 stk_push and stk_pop SHALL never be high in the same cycle; both SHALL be 0 outside ISSUE and DRAIN.
REQ-030 A req arriving during ISSUE/SETTLE/RESP/DRAIN SHALL be latched and served later, never lost.
REQ-031 count SHALL saturate at 0..DEPTH by construction and never wrap.
REQ-032 ready SHALL be 0 in DRAIN and 1 otherwise.

Reset
REQ-033 rst SHALL force state=DRAIN, pend0=pend1=0, count=0, done*=0, err*=0, dout*=0, stk_push=0, round-robin pointer to favour requester 0.
REQ-034 stk_pop SHALL be 0 in the reset cycle and 1 from the first cycle after reset, because the stack pointer is not reset.
REQ-035 rst mid-operation SHALL abort the operation with no done pulse and re-enter DRAIN.

Verification
REQ-036 Stack holding 5 entries, pulse rst -> 6 pops then stk_empty=1; ready rises; count=0.
REQ-037 req0 push 3'b101, then req0 pop -> done0 with err0=0; dout0=3'b101; count goes 0->1->0.
REQ-038 req0 push 2 and req1 push 6 in the same cycle after reset -> requester 0 served first; then requester 1; then two pops return 6 then 2.
REQ-039 Pop at count=0 -> done 2 cycles later; err=1; dout=0; no stk_pop strobe.
REQ-040 32 pushes then a 33rd push -> err=1; count stays 32; then 32 pops return the data in LIFO order.
REQ-041 rst asserted during SETTLE of a pop -> no done pulse; DRAIN runs; count=0.

Source files
------------

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester round-robin arbiter in front of an external push/pop stack
module stack_arbiter #(
   parameter int DEPTH = 32,
   parameter int DW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          op0,
   input  logic          op1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] dout0,
   output logic [DW-1:0] dout1,
   output logic          err0,
   output logic          err1,
   output logic          ready,
   output logic [5:0]    count,
   output logic          stk_push,
   output logic          stk_pop,
   output logic [DW-1:0] stk_din,
   input  logic [DW-1:0] stk_dout,
   input  logic          stk_empty
);

   typedef enum logic [2:0] {
      DRAIN  = 3'd0,
      IDLE   = 3'd1,
      ISSUE  = 3'd2,
      SETTLE = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam logic [5:0] FULL_CNT = 6'(DEPTH);

   state_t        state;
   logic          pend0, pend1;
   logic          hop0, hop1;
   logic [DW-1:0] hdin0, hdin1;
   logic          last;
   logic          win;
   logic          cur_op;

   logic          pick;
   logic          sel_op;
   logic [DW-1:0] sel_din;
   logic          sel_bad;

   // A tie goes to the requester that was not served last.
   always_comb begin
      pick = 1'b0;
      if (pend0 && pend1)
         pick = ~last;
      else if (pend1)
         pick = 1'b1;
      sel_op  = pick ? hop1 : hop0;
      sel_din = pick ? hdin1 : hdin0;
      sel_bad = sel_op ? (count == 6'd0) : (count == FULL_CNT);
   end

   assign ready = (state != DRAIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DRAIN;
         pend0    <= 1'b0;
         pend1    <= 1'b0;
         hop0     <= 1'b0;
         hop1     <= 1'b0;
         hdin0    <= '0;
         hdin1    <= '0;
         last     <= 1'b1;
         win      <= 1'b0;
         cur_op   <= 1'b0;
         count    <= 6'd0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         dout0    <= '0;
         dout1    <= '0;
         stk_push <= 1'b0;
         stk_pop  <= 1'b0;
         stk_din  <= '0;
      end else begin
         if (req0 && !pend0) begin
            pend0 <= 1'b1;
            hop0  <= op0;
            hdin0 <= din0;
         end
         if (req1 && !pend1) begin
            pend1 <= 1'b1;
            hop1  <= op1;
            hdin1 <= din1;
         end

         case (state)
            // Stack pointer is not reset, so pop until the stack reports underflow.
            DRAIN: begin
               if (stk_empty) begin
                  state   <= IDLE;
                  stk_pop <= 1'b0;
               end else begin
                  stk_pop <= 1'b1;
               end
            end

            IDLE: begin
               if (pend0 || pend1) begin
                  win    <= pick;
                  last   <= pick;
                  cur_op <= sel_op;
                  if (pick)
                     pend1 <= 1'b0;
                  else
                     pend0 <= 1'b0;
                  if (sel_bad) begin
                     state <= RESP;
                     if (pick) begin
                        done1 <= 1'b1;
                        err1  <= 1'b1;
                        dout1 <= '0;
                     end else begin
                        done0 <= 1'b1;
                        err0  <= 1'b1;
                        dout0 <= '0;
                     end
                  end else begin
                     state <= ISSUE;
                     if (sel_op) begin
                        stk_pop <= 1'b1;
                     end else begin
                        stk_push <= 1'b1;
                        stk_din  <= sel_din;
                     end
                  end
               end
            end

            ISSUE: begin
               stk_push <= 1'b0;
               stk_pop  <= 1'b0;
               if (cur_op)
                  count <= count - 6'd1;
               else
                  count <= count + 6'd1;
               state <= SETTLE;
            end

            // stk_dout reflects the pop by now; it is captured straight into the response.
            SETTLE: begin
               state <= RESP;
               if (win) begin
                  done1 <= 1'b1;
                  err1  <= 1'b0;
                  dout1 <= cur_op ? stk_dout : '0;
               end else begin
                  done0 <= 1'b1;
                  err0  <= 1'b0;
                  dout0 <= cur_op ? stk_dout : '0;
               end
            end

            RESP: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               dout0 <= '0;
               dout1 <= '0;
               state <= IDLE;
            end

            default: begin
               state    <= DRAIN;
               stk_push <= 1'b0;
               stk_pop  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed vector bench for stack_arbiter with a behavioural stack
module tb_stack_arbiter;

   localparam int DEPTH = 32;
   localparam int DW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, op0, op1;
   logic [DW-1:0] din0, din1;
   logic          done0, done1, err0, err1, ready;
   logic [DW-1:0] dout0, dout1;
   logic [5:0]    count;
   logic          stk_push, stk_pop;
   logic [DW-1:0] stk_din;
   logic [DW-1:0] stk_dout  = '0;
   logic          stk_empty = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stack_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .din0(din0), .din1(din1),
      .done0(done0), .done1(done1), .dout0(dout0), .dout1(dout1),
      .err0(err0), .err1(err1), .ready(ready), .count(count),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
      .stk_dout(stk_dout), .stk_empty(stk_empty)
   );

   // External stack: pointer starts at 5 and is never reset.
   logic [DW-1:0] mem [0:63];
   int ptr             = 5;
   int pop_cnt         = 0;
   int empty_pop_mark  = 0;
   int both_viol       = 0;

   always @(posedge clk) begin
      if (stk_push && stk_pop)
         both_viol <= both_viol + 1;
      if (stk_push) begin
         mem[6'(ptr)] <= stk_din;
         ptr          <= ptr + 1;
         stk_empty    <= 1'b0;
      end else if (stk_pop) begin
         pop_cnt <= pop_cnt + 1;
         if (ptr == 0) begin
            if (!stk_empty)
               empty_pop_mark <= pop_cnt + 1;
            stk_empty <= 1'b1;
         end else begin
            ptr       <= ptr - 1;
            stk_dout  <= mem[6'(ptr - 1)];
            stk_empty <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input string name, input bit n, input bit op, input logic [DW-1:0] d,
                        input bit e_err, input logic [DW-1:0] e_dout, input int e_lat,
                        input logic [5:0] e_cnt);
      int lat;
      int pops0;
      pops0 = pop_cnt;
      if (n) begin req1 = 1'b1; op1 = op; din1 = d; end
      else   begin req0 = 1'b1; op0 = op; din0 = d; end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      lat = 1;
      while ((n ? done1 : done0) !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({name, ".lat"},   32'(lat), 32'(e_lat));
      check({name, ".err"},   32'(n ? err1 : err0), 32'(e_err));
      check({name, ".dout"},  32'(n ? dout1 : dout0), 32'(e_dout));
      check({name, ".other"}, 32'(n ? done0 : done1), 32'd0);
      check({name, ".count"}, 32'(count), 32'(e_cnt));
      if (e_err)
         check({name, ".nopop"}, 32'(pop_cnt - pops0), 32'd0);
      @(negedge clk);
      check({name, ".pulse"}, 32'(n ? done1 : done0), 32'd0);
   endtask

   task automatic wait_ready(input string name, input int maxc);
      int c;
      c = 0;
      while (ready !== 1'b1 && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(ready), 32'd1);
   endtask

   typedef struct {
      bit            n;
      bit            op;
      logic [DW-1:0] din;
      bit            err;
      logic [DW-1:0] dout;
      int            lat;
      logic [5:0]    cnt;
   } vec_t;

   vec_t vt [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int base;
      bit seen;

      // n  op  din   err dout lat cnt
      vt[0] = '{1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 2, 6'd0};
      vt[1] = '{1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 4, 6'd1};
      vt[2] = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd5, 4, 6'd0};
      vt[3] = '{1'b1, 1'b0, 3'd3, 1'b0, 3'd0, 4, 6'd1};
      vt[4] = '{1'b1, 1'b0, 3'd7, 1'b0, 3'd0, 4, 6'd2};
      vt[5] = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd7, 4, 6'd1};
      vt[6] = '{1'b1, 1'b1, 3'd0, 1'b0, 3'd3, 4, 6'd0};
      vt[7] = '{1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 2, 6'd0};

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0; din0 = '0; din1 = '0;
      repeat (3) @(negedge clk);
      check("rst.count", 32'(count), 32'd0);
      check("rst.done",  32'({done0, done1}), 32'd0);
      check("rst.err",   32'({err0, err1}), 32'd0);
      check("rst.dout",  32'({dout0, dout1}), 32'd0);
      check("rst.strobe", 32'({stk_push, stk_pop}), 32'd0);
      check("rst.ready", 32'(ready), 32'd0);

      base = pop_cnt;
      rst = 1'b0;
      @(negedge clk);
      check("drain.pop_first", 32'(stk_pop), 32'd1);
      wait_ready("drain.ready", 50);
      check("drain.pops_to_empty", 32'(empty_pop_mark - base), 32'd6);
      check("drain.count", 32'(count), 32'd0);
      @(negedge clk);
      check("drain.pop_dropped", 32'(stk_pop), 32'd0);

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), vt[i].n, vt[i].op, vt[i].din,
               vt[i].err, vt[i].dout, vt[i].lat, vt[i].cnt);

      // Simultaneous pushes; a second req1 while pend1 is held must be ignored.
      req0 = 1'b1; op0 = 1'b0; din0 = 3'd2;
      req1 = 1'b1; op1 = 1'b0; din1 = 3'd6;
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      req1 = 1'b1; op1 = 1'b0; din1 = 3'd1;
      @(negedge clk);
      req1 = 1'b0;
      lat = 3;
      while (done0 !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
      check("tie.lat0", 32'(lat), 32'd4);
      check("tie.first_not1", 32'(done1), 32'd0);
      while (done1 !== 1'b1 && lat < 16) begin @(negedge clk); lat++; end
      check("tie.lat1", 32'(lat), 32'd8);
      @(negedge clk);
      check("tie.count", 32'(count), 32'd2);
      do_op("tie.pop0", 1'b0, 1'b1, 3'd0, 1'b0, 3'd6, 4, 6'd1);
      do_op("tie.pop1", 1'b1, 1'b1, 3'd0, 1'b0, 3'd2, 4, 6'd0);

      for (int i = 0; i < DEPTH; i++)
         do_op($sformatf("fill%0d", i), 1'b0, 1'b0, 3'(i * 3 + 1), 1'b0, 3'd0, 4, 6'(i + 1));
      do_op("overflow", 1'b1, 1'b0, 3'd4, 1'b1, 3'd0, 2, 6'd32);
      for (int i = DEPTH - 1; i >= 0; i--)
         do_op($sformatf("lifo%0d", i), 1'(i % 2), 1'b1, 3'd0, 1'b0, 3'(i * 3 + 1), 4, 6'(i));

      // Reset while a pop sits in SETTLE.
      do_op("abort.push", 1'b0, 1'b0, 3'd4, 1'b0, 3'd0, 4, 6'd1);
      req0 = 1'b1; op0 = 1'b1; din0 = 3'd0;
      @(negedge clk);
      req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort.done", 32'({done0, done1}), 32'd0);
      check("abort.ready", 32'(ready), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && ready !== 1'b1; c++) begin
         @(negedge clk);
         if (done0 === 1'b1 || done1 === 1'b1)
            seen = 1'b1;
      end
      check("abort.no_done", 32'(seen), 32'd0);
      check("abort.ready_back", 32'(ready), 32'd1);
      check("abort.count", 32'(count), 32'd0);

      check("strobe_exclusive", 32'(both_viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
